router_star_np: RTL and testbench

- Parametrised N-port star-node router, successor to the fixed 2-port node router.
- Each input port has a DEPTH-deep FIFO with a valid/ready handshake.
- Each FIFO head is decoded to an output port. Each output has a round-robin arbiter and a registered output stage with valid/ready back-pressure.
- Sits at the star hub; instantiated once per node, with ports fed by leaf nodes and links.

---
 rtl/router_star_np.sv | 163 ++++++++++++++++
 tb/tb_router_star_np.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/router_star_np.sv
`default_nettype none
// ============================================================================
// Module   : router_star_np
// Brief    : N-port star-hub router. Per-input FIFO, destination decode,
//            per-output round-robin arbiter, registered outputs with
//            valid/ready back-pressure and a saturating illegal-flit counter.
// Revision : 1.0 - initial release
// ============================================================================
module router_star_np #(
    parameter int NPORT = 4,
    parameter int DW    = 16,
    parameter int DEPTH = 4,
    parameter int DESTW = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NPORT*DW-1:0] in_data,
    input  logic [NPORT-1:0]    in_valid,
    output logic [NPORT-1:0]    in_ready,
    output logic [NPORT*DW-1:0] out_data,
    output logic [NPORT-1:0]    out_valid,
    input  logic [NPORT-1:0]    out_ready,
    output logic [7:0]          drop_cnt
);

    localparam int c_aw = $clog2(DEPTH);
    localparam int c_pw = $clog2(NPORT);
    localparam logic [c_aw:0]    c_depth = (c_aw+1)'(DEPTH);
    localparam logic [NPORT-1:0] c_one   = {{(NPORT-1){1'b0}}, 1'b1};

    // Input FIFO state
    logic [DW-1:0]    r_mem [NPORT][DEPTH];
    logic [c_aw-1:0]  r_wp  [NPORT];
    logic [c_aw-1:0]  r_rp  [NPORT];
    logic [c_aw:0]    r_cnt [NPORT];

    // Head decode
    logic [DW-1:0]    w_head [NPORT];
    logic [DESTW-1:0] w_dest [NPORT];
    logic [NPORT-1:0] w_req  [NPORT];   // w_req[p][q]: input p wants output q
    logic [NPORT-1:0] w_nonempty;
    logic [NPORT-1:0] w_illegal;
    logic [NPORT-1:0] w_push;
    logic [NPORT-1:0] w_pop;

    // Arbitration
    logic [c_pw-1:0]  r_ptr      [NPORT];
    logic [c_pw-1:0]  w_gnt_idx  [NPORT];
    logic [DW-1:0]    w_gnt_data [NPORT];
    logic [NPORT-1:0] w_gnt_vld;
    logic [NPORT-1:0] w_can_load;
    logic             w_found;

    // Output stage and drop counter
    logic [DW-1:0]    r_out_data [NPORT];
    logic [NPORT-1:0] r_out_valid;
    logic [7:0]       r_drop;
    logic [3:0]       w_n_drop;
    logic [8:0]       w_drop_sum;

    assign w_push    = in_valid & in_ready;
    assign out_valid = r_out_valid;
    assign drop_cnt  = r_drop;

    // Decode each FIFO head into a one-hot output request or an illegal drop
    always_comb begin
        in_ready   = '0;
        w_nonempty = '0;
        w_illegal  = '0;
        for (int p = 0; p < NPORT; p++) begin
            w_head[p]     = r_mem[p][r_rp[p]];
            w_dest[p]     = w_head[p][DW-1 -: DESTW];
            in_ready[p]   = (r_cnt[p] < c_depth);
            w_nonempty[p] = (r_cnt[p] != '0);
            w_illegal[p]  = w_nonempty[p] && (32'(w_dest[p]) >= 32'(NPORT));
            w_req[p]      = '0;
            if (w_nonempty[p] && !w_illegal[p])
                w_req[p] = c_one << w_dest[p];
        end
    end

    // Round-robin grant per output: scan from ptr upward, then wrap below ptr
    always_comb begin
        w_gnt_vld  = '0;
        w_can_load = '0;
        w_pop      = w_illegal;
        w_n_drop   = '0;
        w_found    = 1'b0;
        for (int q = 0; q < NPORT; q++) begin
            w_gnt_idx[q]  = '0;
            w_gnt_data[q] = '0;
            w_can_load[q] = !r_out_valid[q] || out_ready[q];
            w_found       = 1'b0;
            for (int p = 0; p < NPORT; p++) begin
                if (w_can_load[q] && !w_found && (p >= int'(r_ptr[q])) && w_req[p][q]) begin
                    w_found       = 1'b1;
                    w_gnt_idx[q]  = c_pw'(p);
                    w_gnt_data[q] = w_head[p];
                    w_pop[p]      = 1'b1;
                end
            end
            for (int p = 0; p < NPORT; p++) begin
                if (w_can_load[q] && !w_found && (p < int'(r_ptr[q])) && w_req[p][q]) begin
                    w_found       = 1'b1;
                    w_gnt_idx[q]  = c_pw'(p);
                    w_gnt_data[q] = w_head[p];
                    w_pop[p]      = 1'b1;
                end
            end
            w_gnt_vld[q] = w_found;
        end
        for (int p = 0; p < NPORT; p++)
            w_n_drop = w_n_drop + 4'(w_illegal[p]);
        w_drop_sum = {1'b0, r_drop} + {5'b0, w_n_drop};
    end

    // Flatten the output registers onto the bus
    always_comb begin
        out_data = '0;
        for (int q = 0; q < NPORT; q++)
            out_data[q*DW +: DW] = r_out_data[q];
    end

    // FIFO storage; contents need no reset because occupancy gates every read
    always_ff @(posedge clk) begin
        for (int p = 0; p < NPORT; p++)
            if (w_push[p])
                r_mem[p][r_wp[p]] <= in_data[p*DW +: DW];
    end

    // FIFO pointers, arbiter pointers, output registers and drop counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < NPORT; p++) begin
                r_wp[p]       <= '0;
                r_rp[p]       <= '0;
                r_cnt[p]      <= '0;
                r_ptr[p]      <= '0;
                r_out_data[p] <= '0;
            end
            r_out_valid <= '0;
            r_drop      <= '0;
        end else begin
            for (int p = 0; p < NPORT; p++) begin
                if (w_push[p]) r_wp[p] <= r_wp[p] + 1'b1;
                if (w_pop[p])  r_rp[p] <= r_rp[p] + 1'b1;
                r_cnt[p] <= r_cnt[p] + (c_aw+1)'(w_push[p]) - (c_aw+1)'(w_pop[p]);
            end
            for (int q = 0; q < NPORT; q++) begin
                if (w_gnt_vld[q]) begin
                    r_out_valid[q] <= 1'b1;
                    r_out_data[q]  <= w_gnt_data[q];
                    r_ptr[q]       <= (int'(w_gnt_idx[q]) == NPORT-1) ? '0 : w_gnt_idx[q] + 1'b1;
                end else if (out_ready[q]) begin
                    r_out_valid[q] <= 1'b0;
                end
            end
            r_drop <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_router_star_np.sv
`default_nettype none
// ============================================================================
// Module   : tb_router_star_np
// Brief    : Directed self-checking bench for router_star_np (4-port default
//            instance plus a 3-port instance for illegal destinations).
// Revision : 1.0 - initial release
// ============================================================================
module tb_router_star_np;

    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [4*DW-1:0] in_data4, out_data4;
    logic [3:0]      in_valid4, in_ready4, out_valid4, out_ready4;
    logic [7:0]      drop4;

    logic [3*DW-1:0] in_data3, out_data3;
    logic [2:0]      in_valid3, in_ready3, out_valid3, out_ready3;
    logic [7:0]      drop3;

    int n_assert = 0;
    int n_fail   = 0;

    logic [3:0]  seen;
    logic [15:0] rr_exp [3];

    router_star_np u4 (
        .clk(clk), .rst(rst),
        .in_data(in_data4), .in_valid(in_valid4), .in_ready(in_ready4),
        .out_data(out_data4), .out_valid(out_valid4), .out_ready(out_ready4),
        .drop_cnt(drop4)
    );

    router_star_np #(.NPORT(3), .DW(16), .DEPTH(4), .DESTW(2)) u3 (
        .clk(clk), .rst(rst),
        .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
        .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready3),
        .drop_cnt(drop3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        in_data4 = '0; in_valid4 = '0; out_ready4 = '1;
        in_data3 = '0; in_valid3 = '0; out_ready3 = '1;
        rr_exp[0] = 16'h00A0; rr_exp[1] = 16'h01A1; rr_exp[2] = 16'h03A3;

        // Reset state
        #2;
        check("rst_out_valid", 32'(out_valid4), 32'h0);
        check("rst_out_data",  32'(out_data4 == '0), 32'h1);
        check("rst_in_ready",  32'(in_ready4), 32'hF);
        check("rst_drop",      32'(drop4), 32'h0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // Single flit port 0 -> output 1, two-edge latency
        in_data4[0 +: 16] = 16'h4ABC; in_valid4 = 4'b0001;
        @(negedge clk);
        in_valid4 = '0;
        check("t1_edge1_valid", 32'(out_valid4), 32'h0);
        @(negedge clk);
        check("t1_edge2_valid", 32'(out_valid4), 32'h2);
        check("t1_edge2_data",  32'(out_data4[16 +: 16]), 32'h4ABC);
        @(negedge clk);
        check("t1_drained", 32'(out_valid4), 32'h0);

        // FIFO fill on port 1 toward blocked output 2
        out_ready4 = 4'b1011;
        for (int k = 1; k <= 5; k++) begin
            check($sformatf("t2_ready_%0d", k), 32'(in_ready4[1]), 32'h1);
            in_data4[16 +: 16] = 16'(16'h8000 + k);
            in_valid4[1] = 1'b1;
            @(negedge clk);
        end
        check("t2_full_6th", 32'(in_ready4[1]), 32'h0);
        in_data4[16 +: 16] = 16'h8006;
        @(negedge clk);
        check("t2_still_full", 32'(in_ready4[1]), 32'h0);
        check("t2_hold_valid", 32'(out_valid4[2]), 32'h1);
        check("t2_hold_data",  32'(out_data4[32 +: 16]), 32'h8001);
        in_valid4 = '0;
        out_ready4 = '1;
        for (int k = 2; k <= 5; k++) begin
            @(negedge clk);
            check($sformatf("t2_drain_valid_%0d", k), 32'(out_valid4[2]), 32'h1);
            check($sformatf("t2_drain_data_%0d", k), 32'(out_data4[32 +: 16]), 32'(16'h8000 + k));
        end
        @(negedge clk);
        check("t2_no_sixth", 32'(out_valid4), 32'h0);

        // Round-robin: ports 0, 1, 3 stream to output 0
        in_data4 = {16'h03A3, 16'h0000, 16'h01A1, 16'h00A0};
        in_valid4 = 4'b1011;
        @(negedge clk);
        check("t3_first_edge", 32'(out_valid4[0]), 32'h0);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            check($sformatf("t3_valid_%0d", i), 32'(out_valid4[0]), 32'h1);
            check($sformatf("t3_port_%0d", i), 32'(out_data4[0 +: 16]), 32'(rr_exp[i % 3]));
        end
        check("t3_other_outs", 32'(out_valid4[3:1]), 32'h0);
        in_valid4 = '0;
        repeat (16) @(negedge clk);
        check("t3_flushed", 32'(out_valid4), 32'h0);

        // Parallel paths: port 0 -> output 3, port 3 -> output 0
        for (int k = 0; k < 8; k++) begin
            if (k >= 2) begin
                check($sformatf("t4_valid_%0d", k), 32'(out_valid4), 32'h9);
                check($sformatf("t4_q3_%0d", k), 32'(out_data4[48 +: 16]), 32'(16'hC000 + k - 2));
                check($sformatf("t4_q0_%0d", k), 32'(out_data4[0 +: 16]),  32'(16'h0300 + k - 2));
            end
            if (k < 6) begin
                in_data4[0 +: 16]  = 16'(16'hC000 + k);
                in_data4[48 +: 16] = 16'(16'h0300 + k);
                in_valid4 = 4'b1001;
            end else begin
                in_valid4 = '0;
            end
            @(negedge clk);
        end
        check("t4_done", 32'(out_valid4), 32'h0);

        // Illegal destination on the 3-port instance
        seen = '0;
        for (int k = 0; k < 3; k++) begin
            in_data3[32 +: 16] = 16'(16'hC000 + k);
            in_valid3 = 3'b100;
            @(negedge clk);
            seen[2:0] = seen[2:0] | out_valid3;
        end
        in_valid3 = '0;
        repeat (2) begin
            @(negedge clk);
            seen[2:0] = seen[2:0] | out_valid3;
        end
        check("t5_drop3", 32'(drop3), 32'h3);
        check("t5_no_valid", 32'(seen), 32'h0);
        in_data3[32 +: 16] = 16'h4123; in_valid3 = 3'b100;
        @(negedge clk);
        in_valid3 = '0;
        @(negedge clk);
        check("t5_legal_valid", 32'(out_valid3), 32'h2);
        check("t5_legal_data",  32'(out_data3[16 +: 16]), 32'h4123);
        in_data3[32 +: 16] = 16'hFFFF; in_valid3 = 3'b100;
        repeat (100) @(negedge clk);
        check("t5_drop_102", 32'(drop3), 32'd102);
        repeat (200) @(negedge clk);
        in_valid3 = '0;
        repeat (3) @(negedge clk);
        check("t5_drop_sat", 32'(drop3), 32'd255);

        // Asynchronous reset mid-stream
        out_ready4 = '0;
        in_data4 = {16'hC0AA, 16'h80AA, 16'h40AA, 16'h00AA};
        in_valid4 = 4'hF;
        repeat (3) @(negedge clk);
        check("t6_pre_valid", 32'(out_valid4), 32'hF);
        in_valid4 = '0;
        #2 rst = 1'b1;
        #1;
        check("t6_rst_valid", 32'(out_valid4), 32'h0);
        check("t6_rst_data",  32'(out_data4 == '0), 32'h1);
        check("t6_rst_drop3", 32'(drop3), 32'h0);
        #1 rst = 1'b0;
        @(negedge clk);
        check("t6_in_ready4", 32'(in_ready4), 32'hF);
        check("t6_in_ready3", 32'(in_ready3), 32'h7);
        check("t6_drop3_after", 32'(drop3), 32'h0);
        out_ready4 = '1;
        seen = '0;
        repeat (5) begin
            @(negedge clk);
            seen = seen | out_valid4;
        end
        check("t6_no_stale", 32'(seen), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
